// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the serial PRBS stream.
// It learns the generator state from the received bits, declares lock after
// enough consecutive correct predictions, then free-runs its own copy of the
// sequence and counts received bits that disagree with it.
module prbs_checker #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned ERR_LIMIT = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Longitud,
  input  logic             Dato,
  input  logic             Valido,
  input  logic             Limpiar,
  output logic             Bloqueado,
  output logic             Error,
  output logic [CNT_W-1:0] ConteoErrores,
  output logic [CNT_W-1:0] ConteoBits
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WINDOW + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0]    WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0]    ERR_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  logic [29:0]   r;
  logic [4:0]    fill;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic [1:0]    long_q;

  logic [4:0]    len;
  logic [29:0]   len_mask;
  logic          pred;
  logic          bit_err;

  // Select polynomial length, history mask and predicted next bit.
  always_comb begin
    len      = 5'd6;
    len_mask = 30'h0000_003F;
    pred     = r[5] ^ r[3];
    unique case (Longitud)
      2'b00: begin
        len      = 5'd30;
        len_mask = 30'h3FFF_FFFF;
        pred     = r[29] ^ r[19];
      end
      2'b01: begin
        len      = 5'd25;
        len_mask = 30'h01FF_FFFF;
        pred     = r[24] ^ r[14];
      end
      default: begin
        len      = 5'd6;
        len_mask = 30'h0000_003F;
        pred     = r[5] ^ r[3];
      end
    endcase
    bit_err = Dato ^ pred;
  end

  // Lock FSM, history register, window supervision and error counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= SEARCH;
      r             <= '0;
      fill          <= '0;
      match_cnt     <= '0;
      win_cnt       <= '0;
      win_err       <= '0;
      long_q        <= '0;
      Bloqueado     <= 1'b0;
      Error         <= 1'b0;
      ConteoErrores <= '0;
      ConteoBits    <= '0;
    end else begin
      Error  <= 1'b0;
      long_q <= Longitud;
      if (Longitud != long_q) begin
        state     <= SEARCH;
        Bloqueado <= 1'b0;
        fill      <= '0;
        match_cnt <= '0;
      end else if (Valido) begin
        unique case (state)
          SEARCH: begin
            r <= {r[28:0], Dato};
            if (fill != len) begin
              fill <= fill + 5'd1;
            end else if (!bit_err && ((r & len_mask) != '0)) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                Bloqueado <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the local prediction so a single line error
            // cannot corrupt the history and cascade into further errors.
            r          <= {r[28:0], pred};
            ConteoBits <= (&ConteoBits) ? ConteoBits : ConteoBits + CNT_ONE;
            if (bit_err) begin
              Error         <= 1'b1;
              ConteoErrores <= (&ConteoErrores) ? ConteoErrores : ConteoErrores + CNT_ONE;
            end
            // Limit check takes priority over the window roll-over so an
            // error landing on the last window beat can still drop lock.
            if (bit_err && (win_err == ERR_LAST)) begin
              state     <= SEARCH;
              Bloqueado <= 1'b0;
              fill      <= '0;
              match_cnt <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              win_err <= win_err + EW'(bit_err);
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Clearing overrides any increment made on the same edge.
      if (Limpiar) begin
        ConteoErrores <= '0;
        ConteoBits    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker with a reference PRBS generator.
module tb_prbs_checker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Longitud;
  logic        Dato;
  logic        Valido;
  logic        Limpiar;
  logic        Bloqueado;
  logic        Error;
  logic [31:0] ConteoErrores;
  logic [31:0] ConteoBits;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  logic saw_lock = 1'b0;
  logic [29:0] gen_r;

  always #5 Clk = ~Clk;

  prbs_checker #(
    .CNT_W(32),
    .LOCK_CNT(64),
    .WINDOW(256),
    .ERR_LIMIT(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Longitud(Longitud),
    .Dato(Dato),
    .Valido(Valido),
    .Limpiar(Limpiar),
    .Bloqueado(Bloqueado),
    .Error(Error),
    .ConteoErrores(ConteoErrores),
    .ConteoBits(ConteoBits)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference generator: newest bit = r[A-1]^r[B-1], shifted into r[0].
  task automatic gen_next(output logic b);
    logic nb;
    case (Longitud)
      2'b00:   nb = gen_r[29] ^ gen_r[19];
      2'b01:   nb = gen_r[24] ^ gen_r[14];
      default: nb = gen_r[5] ^ gen_r[3];
    endcase
    gen_r = {gen_r[28:0], nb};
    b = nb;
  endtask

  task automatic cycle(input logic d, input logic v, input logic clr);
    Dato = d;
    Valido = v;
    Limpiar = clr;
    @(posedge Clk);
    #1;
    if (Error) err_pulses++;
    if (Bloqueado) saw_lock = 1'b1;
  endtask

  task automatic beat(input logic flip, input logic clr);
    logic b;
    gen_next(b);
    cycle(b ^ flip, 1'b1, clr);
  endtask

  task automatic expect_lock(input int len, input string tag);
    for (int i = 0; i < len + 63; i++) beat(1'b0, 1'b0);
    chk1({tag, "_before"}, Bloqueado, 1'b0);
    beat(1'b0, 1'b0);
    chk1(tag, Bloqueado, 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    Longitud = 2'b00;
    Dato = 1'b0;
    Valido = 1'b0;
    Limpiar = 1'b0;
    gen_r = 30'h0000_0001;
    #3;
    chk1("rst_bloq", Bloqueado, 1'b0);
    chk1("rst_err", Error, 1'b0);
    chkn("rst_cerr", ConteoErrores, 32'd0);
    chkn("rst_cbits", ConteoBits, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Clean stream, polynomial 30/20: lock after 30+64 beats, no errors.
    expect_lock(30, "lock30");
    err_pulses = 0;
    for (int i = 0; i < 10000; i++) beat(1'b0, 1'b0);
    chkn("clean_cerr", ConteoErrores, 32'd0);
    chkn("clean_cbits", ConteoBits, 32'd10000);
    chkn("clean_pulses", 32'(err_pulses), 32'd0);
    chk1("clean_bloq", Bloqueado, 1'b1);

    // Asynchronous reset mid-cycle, then relock on the continuing stream.
    #3;
    Reset = 1'b1;
    #1;
    chk1("arst_bloq", Bloqueado, 1'b0);
    chk1("arst_err", Error, 1'b0);
    chkn("arst_cbits", ConteoBits, 32'd0);
    chkn("arst_cerr", ConteoErrores, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    expect_lock(30, "relock30");

    // Polynomial 25/15, single flipped bit at beat 500.
    Longitud = 2'b01;
    cycle(1'b0, 1'b0, 1'b1);
    chk1("lchg_bloq", Bloqueado, 1'b0);
    gen_r = 30'h0000_0001;
    expect_lock(25, "lock25");
    err_pulses = 0;
    for (int i = 1; i <= 600; i++) begin
      beat(i == 500, 1'b0);
      if (i == 500) chk1("flip_err_pulse", Error, 1'b1);
      if (i == 501) chk1("flip_err_drop", Error, 1'b0);
    end
    chkn("flip_pulses", 32'(err_pulses), 32'd1);
    chkn("flip_cerr", ConteoErrores, 32'd1);
    chkn("flip_cbits", ConteoBits, 32'd600);
    chk1("flip_bloq", Bloqueado, 1'b1);

    // Polynomial 6/4: 7 errors in one window keep lock, 8 in the next drop it.
    Longitud = 2'b10;
    cycle(1'b0, 1'b0, 1'b1);
    gen_r = 30'h0000_0001;
    expect_lock(6, "lock6");
    for (int i = 1; i <= 300; i++) beat((i % 10 == 0) && (i <= 70), 1'b0);
    chk1("seven_bloq", Bloqueado, 1'b1);
    chkn("seven_cerr", ConteoErrores, 32'd7);
    cycle(1'b0, 1'b0, 1'b1);
    chkn("idle_clr_cerr", ConteoErrores, 32'd0);
    for (int i = 301; i <= 315; i++) begin
      beat(i % 2 == 1, 1'b0);
      if (i == 313) chk1("eight_pre_bloq", Bloqueado, 1'b1);
    end
    chk1("eight_bloq", Bloqueado, 1'b0);
    chkn("eight_cerr", ConteoErrores, 32'd8);
    expect_lock(6, "relock6");

    // Limpiar coinciding with an injected error.
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b0);
    beat(1'b1, 1'b1);
    chk1("clr_err_pulse", Error, 1'b1);
    chkn("clr_cerr", ConteoErrores, 32'd0);
    chkn("clr_cbits", ConteoBits, 32'd0);
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0);
    chkn("clr_cbits5", ConteoBits, 32'd5);
    beat(1'b1, 1'b0);
    chkn("clr_next_cerr", ConteoErrores, 32'd1);
    chkn("clr_next_cbits", ConteoBits, 32'd6);

    // All-zero stream never locks.
    Longitud = 2'b00;
    cycle(1'b0, 1'b0, 1'b1);
    saw_lock = 1'b0;
    err_pulses = 0;
    for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b1, 1'b0);
    chk1("zero_lock", saw_lock, 1'b0);
    chkn("zero_pulses", 32'(err_pulses), 32'd0);
    chkn("zero_cerr", ConteoErrores, 32'd0);
    chkn("zero_cbits", ConteoBits, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
